pipelined_addsub: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; successor to the single-cycle ripple-carry chain in the COMBINATIONAL library.
- Splits a WIDTH-bit operation into STAGES chunks with a registered carry between chunks.
- Accepts one operation per cycle under a valid/ready handshake and provides carry-out and signed overflow flags.
- Used wherever wide add/sub must close timing at high clock rates.

---
 rtl/pipelined_addsub.sv | 124 ++++++++++++
 tb/tb_pipelined_addsub.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk per stage.
// Optional signed saturation of the result when PADDSUB_SATURATE_EN is defined.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;
    // Intermediate register depth; kept at least 1 so STAGES=1 still elaborates.
    localparam int unsigned PD = (STAGES > 1) ? STAGES - 1 : 1;

    logic             en;
    logic [WIDTH-1:0] beff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign beff     = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    // Registers between stage k and stage k+1 (k = 0..STAGES-2).
    logic             valid_q [PD];
    logic             carry_q [PD];
    logic [WIDTH-1:0] a_q     [PD];
    logic [WIDTH-1:0] b_q     [PD];
    logic [WIDTH-1:0] part_q  [PD];

    // Inputs seen by each stage and what it produces.
    logic             stg_v   [STAGES];
    logic             stg_c   [STAGES];
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic [WIDTH-1:0] stg_s   [STAGES];
    logic [WIDTH-1:0] part_d  [STAGES];
    logic             carry_d [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0] chunk;

        if (k == 0) begin : g_first
            assign stg_v[k] = in_valid;
            assign stg_c[k] = c0;
            assign stg_a[k] = a;
            assign stg_b[k] = beff;
            assign stg_s[k] = '0;
        end else begin : g_next
            assign stg_v[k] = valid_q[k-1];
            assign stg_c[k] = carry_q[k-1];
            assign stg_a[k] = a_q[k-1];
            assign stg_b[k] = b_q[k-1];
            assign stg_s[k] = part_q[k-1];
        end

        assign chunk = {1'b0, stg_a[k][k*CW +: CW]} + {1'b0, stg_b[k][k*CW +: CW]}
                     + (CW+1)'(stg_c[k]);
        // Bits above the already-produced chunks are zero, so OR-ing in places this chunk.
        assign part_d[k]  = stg_s[k] | (WIDTH'(chunk[CW-1:0]) << (k * CW));
        assign carry_d[k] = chunk[CW];
    end

    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;
    logic             last_a_msb;
    logic             unused_last;

    assign last_a_msb  = stg_a[STAGES-1][WIDTH-1];
    assign ovf_d       = (last_a_msb == stg_b[STAGES-1][WIDTH-1])
                      && (part_d[STAGES-1][WIDTH-1] != last_a_msb);
    assign unused_last = ^{stg_a[STAGES-1], stg_b[STAGES-1]};

`ifdef PADDSUB_SATURATE_EN
    always_comb begin
        sum_d = part_d[STAGES-1];
        if (ovf_d) begin
            sum_d = last_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_d = part_d[STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(PD); k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                part_q[k]  <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                valid_q[k] <= stg_v[k];
                carry_q[k] <= carry_d[k];
                a_q[k]     <= stg_a[k];
                b_q[k]     <= stg_b[k];
                part_q[k]  <= part_d[k];
            end
            out_valid <= stg_v[STAGES-1];
            sum       <= sum_d;
            cout      <= carry_d[STAGES-1];
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vector table, stall/reset sequences and a randomized
// stream checked against an arithmetic reference model.
module tb_pipelined_addsub;

    localparam int W = 16;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

`ifdef PADDSUB_SATURATE_EN
    localparam logic [W-1:0] POS_OVF_SUM = 16'h7FFF;
    localparam logic [W-1:0] NEG_OVF_SUM = 16'h8000;
`else
    localparam logic [W-1:0] POS_OVF_SUM = 16'h8000;
    localparam logic [W-1:0] NEG_OVF_SUM = 16'h7FFF;
`endif

    res_t exp_q[$];
    res_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic ci, input logic si);
        int   ua, ub, sa, sb, full, sres;
        res_t r;
        ua = int'(ai);
        ub = int'(bi);
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (si) begin
            full = ua - ub + 65536;
            sres = sa - sb;
        end else begin
            full = ua + ub + int'(ci);
            sres = sa + sb + int'(ci);
        end
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (sres > 32767) || (sres < -32768);
`ifdef PADDSUB_SATURATE_EN
        if (r.ovf) r.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Stream monitor: in-order scoreboard fed at input transfers, drained at output transfers.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected output", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stream sum", 32'(sum), 32'(mon_e.sum));
                    check("stream cout", 32'(cout), 32'(mon_e.cout));
                    check("stream ovf", 32'(ovf), 32'(mon_e.ovf));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   nvalid, first, last;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000,    1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE,    1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OVF_SUM, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346,    1'b0, 1'b0};
        vecs[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000,    1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick;
        tick;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // Directed vectors, one at a time, with latency measured from the presenting cycle.
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick;
                lat++;
            end
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(S));
            check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end
        tick;

        // Eight back-to-back operations must emerge on eight consecutive cycles.
        nvalid = 0; first = -1; last = -1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            if (c < 8) drive_rand();
            #1;
            if (c < 8) check("b2b in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = c;
                last = c;
            end
            tick;
        end
        check("b2b out count", 32'(nvalid), 32'd8);
        check("b2b contiguous", 32'(last - first), 32'd7);
        check("b2b first at latency", 32'(first), 32'(S));

        // Fill the pipe, then stall the output for three cycles.
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            in_valid = 1'b1;
            tick;
        end
        for (int s = 0; s < 3; s++) begin
            out_ready = 1'b0;
            drive_rand();
            in_valid = 1'b1;
            #1;
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
            if (exp_q.size() > 0) begin
                check("stall sum held", 32'(sum), 32'(exp_q[0].sum));
                check("stall cout held", 32'(cout), 32'(exp_q[0].cout));
                check("stall ovf held", 32'(ovf), 32'(exp_q[0].ovf));
            end else begin
                check("stall scoreboard empty", 32'd1, 32'd0);
            end
            tick;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick;
        check("stall drained", 32'(exp_q.size()), 32'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            in_valid = 1'b1;
            tick;
        end
        rst = 1'b1;
        drive_rand();
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset sum", 32'(sum), 32'd0);
        check("midreset cout", 32'(cout), 32'd0);
        check("midreset ovf", 32'(ovf), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        check("post-reset drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick;
        check("random drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
